// File: rtl/ts_rate_stuffer_if.sv
// FIFO read side and output byte stream of ts_rate_stuffer.
// master = FIFO/sink environment, slave = the stuffer.
interface ts_rate_stuffer_if #(
    parameter int USEDW_W = 11
) ();
    logic [8:0]         FIFO_Q;
    logic               FIFO_EMPTY;
    logic [USEDW_W-1:0] FIFO_USEDW;
    logic               FIFO_RDREQ;
    logic [7:0]         DATA_OUT;
    logic               D_VALID_OUT;
    logic               P_SYNC_OUT;

    modport master (
        output FIFO_Q, FIFO_EMPTY, FIFO_USEDW,
        input  FIFO_RDREQ,
        input  DATA_OUT, D_VALID_OUT, P_SYNC_OUT
    );

    modport slave (
        input  FIFO_Q, FIFO_EMPTY, FIFO_USEDW,
        output FIFO_RDREQ,
        output DATA_OUT, D_VALID_OUT, P_SYNC_OUT
    );
endinterface

// File: rtl/ts_rate_stuffer.sv
// Constant-rate, packet-aligned TS output: forwards whole buffered packets or stuffs null packets.
// Optional TS_STUFFER_STATS_EN adds NULL_COUNT / PASS_COUNT packet counters.
module ts_rate_stuffer #(
    parameter int BYTE_PERIOD = 4,
    parameter int USEDW_W     = 11,
    parameter int PKT_LEN     = 188
) (
    input  logic               SYS_CLK,
    input  logic               RST,
    ts_rate_stuffer_if.slave   ts,
    output logic               NULL_INS,
    output logic               SYNC_ERR,
    output logic               UNDERRUN
`ifdef TS_STUFFER_STATS_EN
    ,
    output logic [31:0]        NULL_COUNT,
    output logic [31:0]        PASS_COUNT
`endif
);

    localparam int SLOT_W = $clog2(BYTE_PERIOD);
    localparam int IDX_W  = $clog2(PKT_LEN);
    localparam logic [SLOT_W-1:0]  SLOT_LAST = SLOT_W'(BYTE_PERIOD - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(PKT_LEN - 1);
    localparam logic [IDX_W-1:0]   IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0]   IDX_PID_L = IDX_W'(3);
    localparam logic [USEDW_W-1:0] PKT_FILL  = USEDW_W'(PKT_LEN);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_PASS,
        ST_NULL
    } state_t;

    state_t            state_q, state_d;
    logic [SLOT_W-1:0] slot_q;
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic       tick;
    logic       pkt_ready;
    logic       rd;
    logic       discard;
    logic       emit;
    logic       emit_sync;
    logic       emit_null;
    logic       emit_urun;
    logic [7:0] emit_byte;

    assign tick      = (slot_q == '0);
    assign pkt_ready = (ts.FIFO_USEDW >= PKT_FILL) && !ts.FIFO_EMPTY && ts.FIFO_Q[8];

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rd        = 1'b0;
        discard   = 1'b0;
        emit      = 1'b0;
        emit_sync = 1'b0;
        emit_null = 1'b0;
        emit_urun = 1'b0;
        emit_byte = 8'hFF;

        case (state_q)
            ST_IDLE, ST_ALIGN: begin
                if (tick) begin
                    emit      = 1'b1;
                    emit_sync = 1'b1;
                    idx_d     = IDX_ONE;
                    if (pkt_ready) begin
                        state_d   = ST_PASS;
                        emit_byte = ts.FIFO_Q[7:0];
                        rd        = 1'b1;
                    end else begin
                        state_d   = ST_NULL;
                        emit_byte = 8'h47;
                        emit_null = 1'b1;
                    end
                end else if (!ts.FIFO_EMPTY && !ts.FIFO_Q[8]) begin
                    // Misaligned head byte: drop one per non-tick cycle until P_SYNC shows up.
                    rd      = 1'b1;
                    discard = 1'b1;
                    state_d = ST_ALIGN;
                end
            end

            ST_PASS: begin
                if (tick) begin
                    emit = 1'b1;
                    if (!ts.FIFO_EMPTY) begin
                        emit_byte = ts.FIFO_Q[7:0];
                        rd        = 1'b1;
                    end else begin
                        emit_byte = 8'hFF;
                        emit_urun = 1'b1;
                    end
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            ST_NULL: begin
                if (tick) begin
                    emit = 1'b1;
                    // Null header tail: PID 0x1FFF, payload-only, CC 0; payload all 0xFF.
                    if (idx_q == IDX_ONE)
                        emit_byte = 8'h1F;
                    else if (idx_q == IDX_PID_L)
                        emit_byte = 8'h10;
                    else
                        emit_byte = 8'hFF;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Gated by RST so an abandoned packet never pops the FIFO during reset.
    assign ts.FIFO_RDREQ = rd & ~RST;

    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            state_q        <= ST_IDLE;
            slot_q         <= '0;
            idx_q          <= '0;
            ts.DATA_OUT    <= '0;
            ts.D_VALID_OUT <= 1'b0;
            ts.P_SYNC_OUT  <= 1'b0;
            NULL_INS       <= 1'b0;
            SYNC_ERR       <= 1'b0;
            UNDERRUN       <= 1'b0;
        end else begin
            state_q        <= state_d;
            slot_q         <= (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
            idx_q          <= idx_d;
            ts.D_VALID_OUT <= emit;
            if (emit)
                ts.DATA_OUT <= emit_byte;
            ts.P_SYNC_OUT  <= emit & emit_sync;
            NULL_INS       <= emit_null;
            SYNC_ERR       <= discard;
            UNDERRUN       <= emit_urun;
        end
    end

`ifdef TS_STUFFER_STATS_EN
    logic pass_start;
    assign pass_start = emit & emit_sync & ~emit_null;

    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            NULL_COUNT <= '0;
            PASS_COUNT <= '0;
        end else begin
            if (emit_null)
                NULL_COUNT <= NULL_COUNT + 32'd1;
            if (pass_start)
                PASS_COUNT <= PASS_COUNT + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ts_rate_stuffer.sv
// Directed scoreboard bench for ts_rate_stuffer: FIFO model feeds the DUT, expected
// output bytes are queued as stimulus is applied and popped on every D_VALID_OUT strobe.
module tb_ts_rate_stuffer;
    localparam int BP = 4;
    localparam int UW = 11;
    localparam int PL = 188;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ts_rate_stuffer_if #(.USEDW_W(UW)) ts_bus ();
    logic null_ins, sync_err, underrun;
`ifdef TS_STUFFER_STATS_EN
    logic [31:0] null_count, pass_count;
`endif

    ts_rate_stuffer #(
        .BYTE_PERIOD(BP),
        .USEDW_W    (UW),
        .PKT_LEN    (PL)
    ) dut (
        .SYS_CLK (clk),
        .RST     (rst),
        .ts      (ts_bus),
        .NULL_INS(null_ins),
        .SYNC_ERR(sync_err),
        .UNDERRUN(underrun)
`ifdef TS_STUFFER_STATS_EN
        ,
        .NULL_COUNT(null_count),
        .PASS_COUNT(pass_count)
`endif
    );

    typedef struct packed {
        logic [7:0] b;
        logic       sync;
        logic       nul;
        logic       urun;
    } exp_t;

    exp_t       exp_q[$];
    logic [8:0] fifo[$];
    logic [7:0] pkt[PL];
    bit         force_empty = 1'b0;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         last_strobe = -1;
    logic [7:0] hold_exp = 8'h00;
    int         n_rdreq, n_syncerr, n_null, n_urun;

    function automatic void drive_fifo();
        ts_bus.FIFO_EMPTY = force_empty || (fifo.size() == 0);
        ts_bus.FIFO_Q     = (fifo.size() != 0) ? fifo[0] : 9'h000;
        ts_bus.FIFO_USEDW = force_empty ? '0 : UW'(fifo.size());
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic clear_counts();
        n_rdreq = 0; n_syncerr = 0; n_null = 0; n_urun = 0;
    endtask

    task automatic cycle();
        bit   pop;
        exp_t e;
        @(negedge clk);
        if (ts_bus.FIFO_RDREQ) n_rdreq++;
        chk("rdreq_while_empty", 32'(ts_bus.FIFO_RDREQ & ts_bus.FIFO_EMPTY), 32'd0);
        pop = ts_bus.FIFO_RDREQ && (fifo.size() != 0) && !force_empty;
        @(posedge clk);
        #1;
        cyc++;
        if (pop) void'(fifo.pop_front());
        drive_fifo();
        if (sync_err) n_syncerr++;
        if (underrun) n_urun++;
        if (null_ins) n_null++;
        if (ts_bus.D_VALID_OUT) begin
            if (last_strobe >= 0)
                chk("strobe_spacing", 32'(cyc - last_strobe), 32'(BP));
            last_strobe = cyc;
            if (exp_q.size() == 0) begin
                chk("strobe_without_expectation", 32'(ts_bus.D_VALID_OUT), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("data_out",   32'(ts_bus.DATA_OUT),   32'(e.b));
                chk("p_sync_out", 32'(ts_bus.P_SYNC_OUT), 32'(e.sync));
                chk("null_ins",   32'(null_ins),          32'(e.nul));
                chk("underrun",   32'(underrun),          32'(e.urun));
                hold_exp = e.b;
            end
        end else begin
            chk("data_hold",     32'(ts_bus.DATA_OUT), 32'(hold_exp));
            chk("null_ins_idle", 32'(null_ins),        32'd0);
            chk("underrun_idle", 32'(underrun),        32'd0);
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_until_left(input int n, input int budget);
        int k = 0;
        while (exp_q.size() > n && k < budget) begin
            cycle();
            k++;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'(n));
    endtask

    task automatic gen_pkt(input int seed);
        pkt[0] = 8'h47;
        for (int i = 1; i < PL; i++) pkt[i] = 8'(seed * 53 + i * 37);
    endtask

    task automatic fifo_load_pkt();
        for (int i = 0; i < PL; i++) fifo.push_back({(i == 0), pkt[i]});
        drive_fifo();
    endtask

    task automatic exp_push_pkt();
        for (int i = 0; i < PL; i++) exp_q.push_back('{b: pkt[i], sync: (i == 0), nul: 1'b0, urun: 1'b0});
    endtask

    task automatic exp_push_null();
        logic [7:0] b;
        for (int i = 0; i < PL; i++) begin
            b = (i == 0) ? 8'h47 : (i == 1) ? 8'h1F : (i == 3) ? 8'h10 : 8'hFF;
            exp_q.push_back('{b: b, sync: (i == 0), nul: (i == 0), urun: 1'b0});
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_d_valid"}, 32'(ts_bus.D_VALID_OUT), 32'd0);
        chk({tag, "_data"},    32'(ts_bus.DATA_OUT),    32'd0);
        chk({tag, "_p_sync"},  32'(ts_bus.P_SYNC_OUT),  32'd0);
        chk({tag, "_null_ins"},32'(null_ins),           32'd0);
        chk({tag, "_sync_err"},32'(sync_err),           32'd0);
        chk({tag, "_underrun"},32'(underrun),           32'd0);
        chk({tag, "_rdreq"},   32'(ts_bus.FIFO_RDREQ),  32'd0);
    endtask

    initial begin
        logic [8:0] last_word;
        drive_fifo();
        clear_counts();
        run_cycles(3);
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Empty FIFO: back-to-back null packets, no reads.
        clear_counts();
        exp_push_null();
        exp_push_null();
        run_until_left(0, 2000);
        chk("p1_rdreq_count", 32'(n_rdreq), 32'd0);
        chk("p1_null_count",  32'(n_null),  32'd2);

        // Two aligned packets buffered; second decided at USEDW == PKT_LEN exactly.
        clear_counts();
        gen_pkt(1); fifo_load_pkt(); exp_push_pkt();
        gen_pkt(2); fifo_load_pkt(); exp_push_pkt();
        exp_push_null();
        run_until_left(0, 3000);
        chk("p2_rdreq_count", 32'(n_rdreq), 32'd376);
        chk("p2_null_count",  32'(n_null),  32'd1);

        // Five misaligned bytes ahead of an aligned packet.
        clear_counts();
        for (int i = 0; i < 5; i++) fifo.push_back({1'b0, 8'(8'h11 + i)});
        gen_pkt(3);
        fifo_load_pkt();
        exp_push_null();
        exp_push_pkt();
        run_until_left(0, 2000);
        chk("p3_sync_err_count", 32'(n_syncerr), 32'd5);
        chk("p3_rdreq_count",    32'(n_rdreq),   32'd193);

        // USEDW = PKT_LEN-1 at the tick, completed mid-null.
        clear_counts();
        gen_pkt(4);
        exp_push_null();
        exp_push_pkt();
        fifo_load_pkt();
        last_word = fifo.pop_back();
        drive_fifo();
        run_cycles(400);
        chk("p4_rdreq_mid_null", 32'(n_rdreq), 32'd0);
        fifo.push_back(last_word);
        drive_fifo();
        run_until_left(0, 2000);
        chk("p4_rdreq_count", 32'(n_rdreq), 32'd188);

        // One-tick FIFO underrun at PASS byte 100.
        clear_counts();
        gen_pkt(5);
        fifo_load_pkt();
        for (int i = 0; i < PL; i++) begin
            if (i < 100)
                exp_q.push_back('{b: pkt[i], sync: (i == 0), nul: 1'b0, urun: 1'b0});
            else if (i == 100)
                exp_q.push_back('{b: 8'hFF, sync: 1'b0, nul: 1'b0, urun: 1'b1});
            else
                exp_q.push_back('{b: pkt[i-1], sync: 1'b0, nul: 1'b0, urun: 1'b0});
        end
        exp_push_null();
        run_until_left(2 * PL - 100, 1000);
        force_empty = 1'b1;
        drive_fifo();
        run_cycles(BP);
        force_empty = 1'b0;
        drive_fifo();
        run_until_left(0, 2000);
        chk("p5_underrun_count", 32'(n_urun),    32'd1);
        chk("p5_rdreq_count",    32'(n_rdreq),   32'd188);
        chk("p5_sync_err_count", 32'(n_syncerr), 32'd1);

        // Reset asserted at the tick of PASS byte 50.
        clear_counts();
        gen_pkt(6);
        fifo_load_pkt();
        exp_push_pkt();
        run_until_left(PL - 50, 1000);
        run_cycles(BP - 1);
`ifdef TS_STUFFER_STATS_EN
        chk("stats_null_before_rst", null_count, 32'd6);
        chk("stats_pass_before_rst", pass_count, 32'd6);
`endif
        rst = 1'b1;
        #1;
        chk("rdreq_during_rst", 32'(ts_bus.FIFO_RDREQ), 32'd0);
        hold_exp = 8'h00;
        cycle();
        chk_reset_outputs("mid_pkt_reset");
`ifdef TS_STUFFER_STATS_EN
        chk("stats_null_after_rst", null_count, 32'd0);
        chk("stats_pass_after_rst", pass_count, 32'd0);
`endif
        exp_q.delete();
        fifo.delete();
        drive_fifo();
        last_strobe = -1;
        rst = 1'b0;
        clear_counts();
        exp_push_null();
        run_until_left(0, 1000);
        chk("p6_null_count", 32'(n_null), 32'd1);
`ifdef TS_STUFFER_STATS_EN
        chk("stats_null_final", null_count, 32'd1);
        chk("stats_pass_final", pass_count, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ts_rate_stuffer.md
Name: ts_rate_stuffer

Overview:
- Sits directly downstream of the 27 MHz output FIFO of the TS muxer and consumes its show-ahead read side.
- Produces a constant-rate, packet-aligned 188-byte TS stream by forwarding whole packets when at least one full packet is buffered.
- Otherwise inserts null packets (PID 0x1FFF).
- Also realigns on P_SYNC when the FIFO output is mid-packet.

Parameters:
BYTE_PERIOD, 4, SYS_CLK cycles per output byte slot (min 2).
USEDW_W, 11, width of FIFO_USEDW.
PKT_LEN, 188, TS packet length in bytes.

Ports:
SYS_CLK  in  1  27 MHz clock (clk_27 domain).
RST  in  1  synchronous reset, active-high.
FIFO_Q  in  9  show-ahead FIFO word {p_sync, data[7:0]}; valid when FIFO_EMPTY=0.
FIFO_EMPTY  in  1  FIFO read-side empty.
FIFO_USEDW  in  USEDW_W  FIFO read-side fill level in bytes.
FIFO_RDREQ  out  1  pop/acknowledge current FIFO_Q (combinational).
DATA_OUT  out  8  output byte.
D_VALID_OUT  out  1  one-cycle strobe; DATA_OUT/P_SYNC_OUT valid.
P_SYNC_OUT  out  1  high with byte 0 of every output packet.
NULL_INS  out  1  one-cycle pulse with byte 0 of each inserted null packet.
SYNC_ERR  out  1  one-cycle pulse per discarded misaligned FIFO byte.
UNDERRUN  out  1  one-cycle pulse when PASS needs a byte and FIFO is empty.

Behaviour:
- Reset (synchronous, active-high): all outputs 0, state IDLE, slot counter 0, byte index 0. Reset mid-packet abandons the packet. The first slot after reset starts a fresh packet.
- Slot counter: counts 0..BYTE_PERIOD-1 and wraps. Tick = (counter==0). Exactly one output byte per tick.
- Output timing: the byte chosen in the tick cycle is registered onto DATA_OUT/P_SYNC_OUT with D_VALID_OUT=1 in the following cycle only. DATA_OUT holds its value until the next strobe.
- States: IDLE, ALIGN, PASS, NULL.
- IDLE/ALIGN, non-tick cycle:
  - If FIFO_EMPTY=0 and FIFO_Q[8]=0: assert FIFO_RDREQ, pulse SYNC_ERR, go to ALIGN (discard, 1 byte/cycle).
  - If FIFO_Q[8]=1, or FIFO is empty: hold.
- IDLE/ALIGN, tick: if FIFO_USEDW >= PKT_LEN, FIFO_EMPTY=0 and FIFO_Q[8]=1:
  - Go to PASS.
  - Emit FIFO_Q[7:0] with P_SYNC_OUT=1 and assert FIFO_RDREQ.
  - Set byte index to 1.
- IDLE/ALIGN, tick, PASS conditions not met:
  - Go to NULL and emit 0x47 with P_SYNC_OUT=1.
  - Pulse NULL_INS with that strobe.
  - Set index to 1.
  - A misaligned byte at the tick is not discarded in that cycle.
- PASS, tick:
  - FIFO_EMPTY=0: emit FIFO_Q[7:0] with P_SYNC_OUT=0 and assert FIFO_RDREQ. FIFO_Q[8] is ignored mid-packet.
  - FIFO_EMPTY=1: emit 0xFF, no RDREQ, pulse UNDERRUN.
  - Index increments either way.
- NULL, tick: emit by index. 1→0x1F, 2→0xFF, 3→0x10, 4..187→0xFF. P_SYNC_OUT=0. Index increments.
- Packet end: after emitting index PKT_LEN-1, return to IDLE. The next tick begins a new packet with no gap slot.
- FIFO_RDREQ is never asserted when FIFO_EMPTY=1.
- Non-tick cycles in PASS/NULL: no RDREQ and no output change.
- Decision fill level: FIFO_USEDW exactly PKT_LEN → PASS; PKT_LEN-1 → NULL.

Optional Feature:
Macro TS_STUFFER_STATS_EN.
- Defined: adds outputs NULL_COUNT[31:0] and PASS_COUNT[31:0].
  - Counters increment at the start of each null / passed packet.
  - Both wrap at 2^32.
  - Both cleared by RST.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- FIFO empty after reset, BYTE_PERIOD=4 → continuous null packets: bytes 47 1F FF 10 FF…FF (188). D_VALID_OUT every 4th cycle. NULL_INS once per 188 strobes. FIFO_RDREQ never high.
- FIFO preloaded with 2 aligned packets (USEDW=376) → two passed packets byte-exact, P_SYNC_OUT on bytes 0 and 188, then null packets. 376 RDREQ pulses total.
- FIFO holds 5 bytes with p_sync=0, then an aligned packet → 5 SYNC_ERR pulses and 5 discards. The next packet starts with FIFO byte 0x47. No output byte lost or duplicated.
- USEDW=187 at a tick → null packet emitted. USEDW reaching 188 mid-null → PASS begins at the first tick after the null ends.
- Force FIFO_EMPTY=1 at PASS byte 100 for one tick → byte 100 = 0xFF and UNDERRUN pulses once. The packet is still 188 bytes and the next P_SYNC_OUT falls 188 strobes after the previous one.
- Assert RST at PASS byte 50 → next cycle all outputs 0. After release, the first strobe carries P_SYNC_OUT=1. With TS_STUFFER_STATS_EN, the counters read 0.
